stage_execute: RTL
==================

# stage_execute

Pipeline execute stage of the 5-stage RV32I core, between decode and `stage_memory`. It resolves operands through forwarding, runs the ALU, and resolves branches and jumps. It registers every result into the execute/memory pipeline register that drives the `execute_*` inputs of the memory stage. An optional two-cycle multiplier adds the RV32M MUL subset.

## Interface
- No parameters.
- `clk` in 1: core clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `decode_valid` in 1: decode presents a real instruction; 0 means bubble.
- `flush` in 1: hazard-unit squash; the result of this cycle becomes a bubble.
- `decode_rs1`, `decode_rs2` in 5: source register indices, used for forwarding.
- `decode_rs1_data`, `decode_rs2_data` in 32: register-file read values.
- `decode_imm`, `decode_pc`, `decode_instr_addr_plus` in 32: immediate, PC, and PC+4.
- `decode_alu_ctrl` in 4: ALU operation (encoding below).
- `decode_alu_src` in 1: 0 selects rs2 as operand B; 1 selects imm.
- `decode_branch`, `decode_jal`, `decode_jalr` in 1: control-transfer class.
- `decode_funct3` in 3: branch condition and load/store size.
- `decode_rd` in 5, `decode_regfile_wr_enable` in 1, `decode_datamem_wr_enable` in 1, `decode_result_src` in 2: passthrough controls.
- `mem_rd` in 5, `mem_regfile_wr_enable` in 1, `mem_alu_result` in 32: memory-stage forward source.
- `wb_rd` in 5, `wb_regfile_wr_enable` in 1, `wb_result` in 32: writeback forward source.
- `execute_rd` out 5, `execute_regfile_wr_enable` out 1, `execute_datamem_wr_enable` out 1, `execute_result_src` out 2, `execute_funct3` out 3: registered controls.
- `execute_alu_result`, `execute_wr_datamem_data`, `execute_instr_addr_plus` out 32: registered data.
- `execute_pc_redirect` out 1, `execute_pc_target` out 32: registered taken-branch/jump redirect to fetch.
- `execute_busy` out 1: combinational; upstream holds its current instruction while high.

## Operation
- Forwarding, per source: if `rs==0`, use the raw register-file data. Else if `mem_regfile_wr_enable && mem_rd==rs`, use `mem_alu_result`. Else if the `wb_*` sources match, use `wb_result`. Else use the raw data. Mem has priority over wb.
- Load-use stalls are the hazard unit's job; this stage never detects them.
- Operand A is forwarded rs1. Operand B is `decode_imm` if `decode_alu_src` is 1, else forwarded rs2.
- `execute_wr_datamem_data` always takes forwarded rs2.
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B (LUI), 11 PC+B (AUIPC).
- ALU arithmetic: all operations are modulo 2^32. Shift amount is `B[4:0]`. SLT and SLTU produce 0 or 1.
- Codes 12–15 are MUL, MULH, MULHSU, MULHU when `EXECUTE_MUL_EN` is defined. Otherwise they give result 0.
- Branch conditions (`funct3`): 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Codes 010 and 011 are never taken.
- Branch compare uses forwarded rs1 against forwarded rs2.
- JAL target is `pc+imm`. JALR target is `(rs1+imm)&~1`. Branch target is `pc+imm`.
- Redirect fires when the instruction is valid and is (taken branch, JAL, or JALR).
- Bubble, produced on `!decode_valid`, `flush`, or while `execute_pc_redirect` is 1 (wrong-path squash):
  - registers `rd=0`, both write enables 0 and redirect 0;
  - registers all other outputs as 0.
- Otherwise, all `execute_*` outputs register the computed/passthrough values.

## Timing
- Reset: every registered output is 0 and the FSM is IDLE. Reset asserted mid-multiply aborts the multiply.
- Latency is 1 cycle for non-MUL operations. Inputs sampled at edge N appear on `execute_*` after edge N.
- `execute_pc_redirect` is high for exactly one cycle per taken transfer. The instruction presented during that cycle is squashed.
- FSM (only with `EXECUTE_MUL_EN`):
  - **IDLE to MUL_WAIT** on a valid MUL, no flush and no redirect. The stage captures operands internally, `execute_busy` is 1, and the edge registers a bubble.
  - **MUL_WAIT to IDLE** on the next edge. The held instruction is re-presented, but the product is computed from the captured operands. The stage registers the result, and `execute_busy` is 0.
  - **`flush` in MUL_WAIT:** registers a bubble, returns to IDLE, and discards the product.
- `execute_busy` is 0 whenever the FSM is not about to accept a MUL. It is never 1 without the macro.

## Configuration
- `EXECUTE_MUL_EN` defined:
  - ALU codes 12–15 take the two-cycle multiply path. MUL returns the low 32 bits. MULH, MULHSU and MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands.
- `EXECUTE_MUL_EN` undefined:
  - no multiplier and no FSM;
  - codes 12–15 yield 0 in one cycle;
  - `execute_busy` is tied to 0.

## Test plan
- ADD with forwarding: rs1=x5 (regfile 1), `mem_rd`=5 with enable and `mem_alu_result`=100; wb also targets x5 with 7. Expect `execute_alu_result`=100+B, showing mem priority.
- x0 guard: rs1=0 with `mem_rd`=0 and enable 1, `mem_alu_result`=55. Expect operand A=0.
- BLT taken: rs1=0xFFFFFFFF, rs2=1, pc=0x40, imm=-8. Expect one cycle with redirect=1 and target 0x38. The next presented ADD becomes a bubble (rd=0, wr_enable=0).
- JALR: rs1=0x101, imm=2. Expect target 0x102 and redirect=1. `execute_instr_addr_plus` equals `decode_instr_addr_plus`.
- SRA and SLTU: A=0x80000000 with B=4 gives 0xF8000000. SLTU with 1 and 0xFFFFFFFF gives 1.
- With `EXECUTE_MUL_EN`, MULH of 0xFFFFFFFF and 0xFFFFFFFF: `execute_busy` is 1 for one cycle, then the result is 0x00000000. MULHU of the same operands gives 0xFFFFFFFE. Asserting `rst_n`=0 during MUL_WAIT clears every output to 0.

Source files
------------

// File: rtl/stage_execute.sv
// stage_execute: RV32I execute stage with operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Define EXECUTE_MUL_EN to add the two-cycle RV32M MUL/MULH/MULHSU/MULHU path on ALU codes 12-15.
module stage_execute (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decode_valid,
    input  logic        flush,
    input  logic [4:0]  decode_rs1,
    input  logic [4:0]  decode_rs2,
    input  logic [31:0] decode_rs1_data,
    input  logic [31:0] decode_rs2_data,
    input  logic [31:0] decode_imm,
    input  logic [31:0] decode_pc,
    input  logic [31:0] decode_instr_addr_plus,
    input  logic [3:0]  decode_alu_ctrl,
    input  logic        decode_alu_src,
    input  logic        decode_branch,
    input  logic        decode_jal,
    input  logic        decode_jalr,
    input  logic [2:0]  decode_funct3,
    input  logic [4:0]  decode_rd,
    input  logic        decode_regfile_wr_enable,
    input  logic        decode_datamem_wr_enable,
    input  logic [1:0]  decode_result_src,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regfile_wr_enable,
    input  logic [31:0] mem_alu_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regfile_wr_enable,
    input  logic [31:0] wb_result,
    output logic [4:0]  execute_rd,
    output logic        execute_regfile_wr_enable,
    output logic        execute_datamem_wr_enable,
    output logic [1:0]  execute_result_src,
    output logic [2:0]  execute_funct3,
    output logic [31:0] execute_alu_result,
    output logic [31:0] execute_wr_datamem_data,
    output logic [31:0] execute_instr_addr_plus,
    output logic        execute_pc_redirect,
    output logic [31:0] execute_pc_target,
    output logic        execute_busy
);
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_PCB   = 4'd11;

    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b;
    logic [31:0] alu_out, ex_result, pc_target;
    logic        br_taken, redirect_now, squash, bubble, mul_start;

    // Mem stage is younger than writeback, so it wins; x0 never forwards.
    always_comb begin
        rs1_fwd = decode_rs1_data;
        if (decode_rs1 != 5'd0) begin
            if (mem_regfile_wr_enable && mem_rd == decode_rs1)
                rs1_fwd = mem_alu_result;
            else if (wb_regfile_wr_enable && wb_rd == decode_rs1)
                rs1_fwd = wb_result;
        end
        rs2_fwd = decode_rs2_data;
        if (decode_rs2 != 5'd0) begin
            if (mem_regfile_wr_enable && mem_rd == decode_rs2)
                rs2_fwd = mem_alu_result;
            else if (wb_regfile_wr_enable && wb_rd == decode_rs2)
                rs2_fwd = wb_result;
        end
    end

    assign op_a = rs1_fwd;
    assign op_b = decode_alu_src ? decode_imm : rs2_fwd;

    always_comb begin
        alu_out = '0;
        case (decode_alu_ctrl)
            ALU_ADD:   alu_out = op_a + op_b;
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_OR:    alu_out = op_a | op_b;
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SLT:   alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_out = {31'd0, op_a < op_b};
            ALU_SLL:   alu_out = op_a << op_b[4:0];
            ALU_SRL:   alu_out = op_a >> op_b[4:0];
            ALU_SRA:   alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_PASSB: alu_out = op_b;
            ALU_PCB:   alu_out = decode_pc + op_b;
            default:   alu_out = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (decode_funct3)
            3'b000:  br_taken = (rs1_fwd == rs2_fwd);
            3'b001:  br_taken = (rs1_fwd != rs2_fwd);
            3'b100:  br_taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            3'b101:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'b110:  br_taken = (rs1_fwd <  rs2_fwd);
            3'b111:  br_taken = (rs1_fwd >= rs2_fwd);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_target    = decode_jalr ? ((rs1_fwd + decode_imm) & ~32'd1)
                                      : (decode_pc + decode_imm);
    assign redirect_now = decode_valid &&
                          ((decode_branch && br_taken) || decode_jal || decode_jalr);
    // A redirect in flight means the instruction now in decode is on the wrong path.
    assign squash       = !decode_valid || flush || execute_pc_redirect;
    assign bubble       = squash || mul_start;

`ifdef EXECUTE_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL_WAIT = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] mul_a, mul_b, mul_result;
    logic [1:0]  mul_op;
    logic [32:0] mul_sa, mul_sb;
    logic [63:0] mul_prod;
    logic        is_mul;

    assign is_mul = (decode_alu_ctrl[3:2] == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_op <= '0;
        end else begin
            state <= state_next;
            if (mul_start) begin
                mul_a  <= op_a;
                mul_b  <= op_b;
                mul_op <= decode_alu_ctrl[1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul && !squash) begin
                    mul_start  = 1'b1;
                    state_next = MUL_WAIT;
                end
            end
            MUL_WAIT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // 33-bit operands carry the per-op signedness; low 64 bits of the product are exact.
    assign mul_sa     = {(mul_op == 2'b01 || mul_op == 2'b10) && mul_a[31], mul_a};
    assign mul_sb     = {(mul_op == 2'b01) && mul_b[31], mul_b};
    assign mul_prod   = $signed({{31{mul_sa[32]}}, mul_sa}) * $signed({{31{mul_sb[32]}}, mul_sb});
    assign mul_result = (mul_op == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
    assign ex_result  = (state == MUL_WAIT) ? mul_result : alu_out;
    assign execute_busy = mul_start;
`else
    assign mul_start    = 1'b0;
    assign ex_result    = alu_out;
    assign execute_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            execute_rd                <= '0;
            execute_regfile_wr_enable <= 1'b0;
            execute_datamem_wr_enable <= 1'b0;
            execute_result_src        <= '0;
            execute_funct3            <= '0;
            execute_alu_result        <= '0;
            execute_wr_datamem_data   <= '0;
            execute_instr_addr_plus   <= '0;
            execute_pc_redirect       <= 1'b0;
            execute_pc_target         <= '0;
        end else if (bubble) begin
            execute_rd                <= '0;
            execute_regfile_wr_enable <= 1'b0;
            execute_datamem_wr_enable <= 1'b0;
            execute_result_src        <= '0;
            execute_funct3            <= '0;
            execute_alu_result        <= '0;
            execute_wr_datamem_data   <= '0;
            execute_instr_addr_plus   <= '0;
            execute_pc_redirect       <= 1'b0;
            execute_pc_target         <= '0;
        end else begin
            execute_rd                <= decode_rd;
            execute_regfile_wr_enable <= decode_regfile_wr_enable;
            execute_datamem_wr_enable <= decode_datamem_wr_enable;
            execute_result_src        <= decode_result_src;
            execute_funct3            <= decode_funct3;
            execute_alu_result        <= ex_result;
            execute_wr_datamem_data   <= rs2_fwd;
            execute_instr_addr_plus   <= decode_instr_addr_plus;
            execute_pc_redirect       <= redirect_now;
            execute_pc_target         <= pc_target;
        end
    end
endmodule
